// File: rtl/dsp_coprocessor.sv
// Iterative shift-add multiply / multiply-accumulate coprocessor that answers the
// CPU pipeline's start_dsp/op_dsp offload port with a busy/done handshake.
module dsp_coprocessor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_dsp,
  input  logic [1:0]       op_dsp,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MULT  = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MAC   = 2'd1;
  localparam logic [1:0] OP_CLR   = 2'd2;
  localparam logic [1:0] OP_RDACC = 2'd3;

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [1:0]       state_q,  state_d;
  logic [1:0]       op_q,     op_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q,   prod_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q,    cnt_d;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no path leaves one unassigned (no latch).
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        // Operands are captured only under start_dsp, so an undriven opcode never gets in.
        if (start_dsp) begin
          op_d     = op_dsp;
          mcand_d  = op_a;
          mplier_d = op_b;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = S_MULT;
        end
      end
      S_MULT: begin
        if (op_q == OP_CLR) begin
          acc_d    = '0;
          result_d = '0;
          state_d  = S_DONE;
        end else if (op_q == OP_RDACC) begin
          result_d = acc_q;
          state_d  = S_DONE;
        end else if (cnt_q == LAST) begin
          if (op_q == OP_MAC) begin
            state_d = S_ACCUM;
          end else begin
            result_d = prod_q;
            state_d  = S_DONE;
          end
        end else begin
          // Always WIDTH iterations: latency must not depend on the operands.
          if (mcand_q[0]) prod_d = prod_q + mplier_q;
          mplier_d = mplier_q << 1;
          mcand_d  = mcand_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      S_ACCUM: begin
        acc_d    = acc_q + prod_q;
        result_d = acc_q + prod_q;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy    = (state_q == S_MULT) || (state_q == S_ACCUM);
  assign done    = (state_q == S_DONE);
  assign result  = result_q;
  assign acc_out = acc_q;

endmodule
